// File: rtl/regfile_sb.sv
// Integer register file with a per-register busy scoreboard.
// Feeds registered rs1/rs2 operands to the ALU execute units and accepts
// their rd results on writeback. Reads of registers with an in-flight
// writer are rejected via a combinational stall.
//
// Read handshake: rd_req is the request and !stall is the accept. A read is
// taken only on a posedge where rd_req=1 and stall=0. The operand pair then
// appears on rs1/rs2 on the following cycle, with op_valid pulsed high for
// exactly that one cycle. When a read is rejected, the requester keeps rd_req
// (and its addresses) asserted and retries. rs1/rs2 hold their last values
// whenever op_valid is low.
module regfile_sb #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rd_req,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1,
    output logic [XLEN-1:0] rs2,
    output logic            op_valid,
    output logic            stall,
    input  logic            issue_en,
    input  logic [AW-1:0]   issue_addr,
    input  logic            wb_en,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] rd
);

    // Architectural state: one data word and one busy bit per register.
    logic [XLEN-1:0] mem  [NREG];
    logic            busy [NREG];

    // Combinational hazard, forwarding and accept terms.
    logic            haz1;
    logic            haz2;
    logic            rd_accept;
    logic [XLEN-1:0] val1;
    logic [XLEN-1:0] val2;

    // Per-register storage. Register 0 is a constant zero that is never busy,
    // so reads of it cannot stall and writes to it have nowhere to land.
    for (genvar g = 0; g < NREG; g++) begin : g_reg
        if (g == 0) begin : g_zero
            assign mem[g]  = '0;
            assign busy[g] = 1'b0;
        end else begin : g_live
            logic hit_wb;
            logic hit_issue;

            assign hit_wb    = wb_en    && (wb_addr    == AW'(g));
            assign hit_issue = issue_en && (issue_addr == AW'(g));

            // Data word: cleared on reset, written by writeback.
            always_ff @(posedge clk) begin
                if (rst) begin
                    mem[g] <= '0;
                end else if (hit_wb) begin
                    mem[g] <= rd;
                end
            end

            // Busy bit: issue sets, writeback clears. Issue is checked first
            // so a new writer dispatched as the old one retires stays pending.
            always_ff @(posedge clk) begin
                if (rst) begin
                    busy[g] <= 1'b0;
                end else if (hit_issue) begin
                    busy[g] <= 1'b1;
                end else if (hit_wb) begin
                    busy[g] <= 1'b0;
                end
            end
        end
    end

    // Hazard detection: a pending register blocks a read unless its
    // writeback is arriving this very cycle. Issues made this cycle only
    // take effect from the next cycle, through the busy register.
    always_comb begin
        haz1      = busy[rs1_addr] && !(wb_en && (wb_addr == rs1_addr));
        haz2      = busy[rs2_addr] && !(wb_en && (wb_addr == rs2_addr));
        stall     = rd_req && (haz1 || haz2);
        rd_accept = rd_req && !stall;
    end

    // Operand values with write-through forwarding of a same-cycle writeback.
    // Address 0 falls through to mem[0], which is tied to zero.
    always_comb begin
        val1 = mem[rs1_addr];
        val2 = mem[rs2_addr];
        if (wb_en && (wb_addr == rs1_addr) && (rs1_addr != '0)) begin
            val1 = rd;
        end
        if (wb_en && (wb_addr == rs2_addr) && (rs2_addr != '0)) begin
            val2 = rd;
        end
    end

    // Operand register: capture on an accepted read and pulse op_valid.
    // Otherwise hold the operands and drop op_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            rs1      <= '0;
            rs2      <= '0;
            op_valid <= 1'b0;
        end else if (rd_accept) begin
            rs1      <= val1;
            rs2      <= val2;
            op_valid <= 1'b1;
        end else begin
            op_valid <= 1'b0;
        end
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Integer register file with scoreboard; sits directly upstream of the ALU execute units (alu_or and siblings).
- Supplies registered rs1/rs2 operands to the ALU and accepts the ALU's rd result on writeback.
- Tracks pending destination writes with per-register busy bits and stalls operand reads that hit an in-flight register.

Parameters:
XLEN, 32, data width of each register and of the rs1/rs2/rd buses
NREG, 32, number of architectural registers; register 0 is hardwired to zero
AW, 5, register address width; must equal log2(NREG)

Ports:
clk  input  1  system clock; all state updates on posedge
rst  input  1  synchronous, active-high reset
rd_req  input  1  operand read request for rs1_addr/rs2_addr this cycle
rs1_addr  input  AW  source register 1 address
rs2_addr  input  AW  source register 2 address
rs1  output  XLEN  registered operand 1 to ALU
rs2  output  XLEN  registered operand 2 to ALU
op_valid  output  1  rs1/rs2 hold a freshly read operand pair (one-cycle pulse per accepted read)
stall  output  1  combinational; current rd_req is rejected this cycle
issue_en  input  1  mark issue_addr as pending (instruction dispatched)
issue_addr  input  AW  destination register being dispatched
wb_en  input  1  writeback strobe from ALU
wb_addr  input  AW  writeback destination address
rd  input  XLEN  writeback data (ALU result)

Behaviour:
- Reset (rst=1 at posedge):
  - All registers become 0 and all busy bits clear.
  - rs1 and rs2 become 0; op_valid becomes 0.
  - Any in-flight issue, writeback or read in that cycle is discarded.
  - stall is 0 in the cycle after reset.
- Register 0:
  - Always reads 0.
  - Writes to it are ignored.
  - issue_en to it never sets its busy bit, so reads of register 0 never stall.
- Hazard / stall (combinational):
  - hazN = busy[rsN_addr] && !(wb_en && wb_addr==rsN_addr).
  - stall = rd_req && (haz1 || haz2). A writeback in the same cycle resolves the hazard.
- Read (1-cycle latency):
  - If rd_req && !stall at posedge: rs1 <= value(rs1_addr), rs2 <= value(rs2_addr), and op_valid <= 1.
  - Otherwise op_valid <= 0 and rs1/rs2 hold their previous values.
- Write-through forwarding:
  - value(a) = rd if (wb_en && wb_addr==a && a!=0), else mem[a].
  - Read and writeback to the same address in the same cycle therefore returns the new data.
- Writeback: when wb_en, mem[wb_addr] <= rd (unless address 0) and busy[wb_addr] <= 0.
- Issue: when issue_en, busy[issue_addr] <= 1 (unless address 0).
  - Issue to an already-busy register is legal; the bit stays set.
- Simultaneous issue and wb to the same address: data is written and busy ends SET (issue wins). This models a new writer dispatched as the old one retires.
- Independence: issue, wb and read are independent and may all occur in the same cycle. Issue does not affect stall in the same cycle; busy updates are visible from the next cycle.
- No ordering between writebacks is enforced; the last wb to an address wins.

Test Plan:
1. Reset, then read with rd_req=1, rs1_addr=3, rs2_addr=0 -> next cycle rs1=0, rs2=0, op_valid=1, stall=0.
2. Write back wb_addr=5, rd=0xFFFFFFFF; next cycle write back wb_addr=6, rd=0; then read rs1_addr=5, rs2_addr=6 -> rs1=0xFFFFFFFF, rs2=0, op_valid=1 one cycle after the read.
3. Forwarding: wb_en=1, wb_addr=7, rd=0x0000FFFF in the same cycle as rd_req with rs1_addr=7 -> stall=0, next cycle rs1=0x0000FFFF.
4. Scoreboard:
   - issue_addr=9; next cycle rd_req with rs2_addr=9 -> stall=1, op_valid stays 0, rs1/rs2 unchanged.
   - wb_addr=9, rd=0x12345678 in the same cycle as that read -> stall=0, rs2=0x12345678 next cycle.
5. Simultaneous issue_en and wb_en to address 4 (rd=0xA5A5A5A5) -> mem[4]=0xA5A5A5A5 but a read of 4 next cycle stalls. Separately, wb_addr=0 with rd=0xFFFFFFFF, then read address 0 -> 0.
6. Reset mid-operation: set busy on 10 and 11, assert rst for one cycle with wb_en=1 to 12 -> afterwards reading 10, 11 and 12 gives stall=0 and all values 0.
